// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcodes, state enum, select encodings and state-to-control decode for the multicycle controller.
// S_TRAP exists only when MC_CTRL_ILLEGAL_TRAP_EN is defined.
package mc_ctrl_pkg;
  localparam int OP_W = 7;
  localparam int ST_W = 4;
  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;
  localparam logic [1:0] RS_ALUOUT = 2'b00, RS_DATA = 2'b01, RS_ALURES = 2'b10;
  localparam logic [1:0] SA_PC = 2'b00, SA_OLDPC = 2'b01, SA_RD1 = 2'b10;
  localparam logic [1:0] SB_RD2 = 2'b00, SB_IMM = 2'b01, SB_FOUR = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11;
  typedef enum logic [ST_W-1:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;
  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       mem_write;
    logic       fetch;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;
  function automatic ctrl_t ctrl_dec(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_req = 1'b1; c.fetch = 1'b1; c.result_src = RS_ALURES; c.alu_src_a = SA_PC; c.alu_src_b = SB_FOUR; c.alu_op = ALU_ADD; end
      S_DECODE:   begin c.alu_src_a = SA_OLDPC; c.alu_src_b = SB_IMM; c.alu_op = ALU_ADD; end
      S_MEMADR:   begin c.alu_src_a = SA_RD1; c.alu_src_b = SB_IMM; c.alu_op = ALU_ADD; end
      S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; c.result_src = RS_ALUOUT; end
      S_MEMWB:    begin c.result_src = RS_DATA; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_write = 1'b1; c.result_src = RS_ALUOUT; end
      S_EXECR:    begin c.alu_src_a = SA_RD1; c.alu_src_b = SB_RD2; c.alu_op = ALU_FUNCT; end
      S_EXECI:    begin c.alu_src_a = SA_RD1; c.alu_src_b = SB_IMM; c.alu_op = ALU_FUNCT; end
      S_ALUWB:    begin c.result_src = RS_ALUOUT; c.reg_write = 1'b1; end
      S_BEQ:      begin c.alu_src_a = SA_RD1; c.alu_src_b = SB_RD2; c.alu_op = ALU_SUB; c.result_src = RS_ALUOUT; c.branch = 1'b1; end
      S_JAL:      begin c.alu_src_a = SA_OLDPC; c.alu_src_b = SB_FOUR; c.alu_op = ALU_ADD; c.result_src = RS_ALUOUT; c.pc_update = 1'b1; end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:     c.illegal = 1'b1;
`endif
      default:    c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: controller-to-datapath control bus; slave = controller, master = datapath/memory side.
interface mc_ctrl_if;
  import mc_ctrl_pkg::*;
  logic [OP_W-1:0] op;
  logic            zero;
  logic            mem_ready;
  logic            mem_req;
  logic            adr_src;
  logic            mem_write;
  logic            ir_write;
  logic            pc_write;
  logic            reg_write;
  logic [1:0]      result_src;
  logic [1:0]      alu_src_a;
  logic [1:0]      alu_src_b;
  logic [1:0]      alu_op;
  logic [1:0]      imm_src;
  logic            illegal_op;
  modport slave (
    input  op, zero, mem_ready,
    output mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal_op
  );
  modport master (
    output op, zero, mem_ready,
    input  mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal_op
  );
endinterface

// File: rtl/mc_imm_dec.sv
// mc_imm_dec: opcode to immediate-format select, purely combinational.
module mc_imm_dec
  import mc_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  output logic [1:0]      o_imm_src
);
  assign o_imm_src = (i_op == OP_SW)  ? IMM_S :
                     (i_op == OP_BEQ) ? IMM_B :
                     (i_op == OP_JAL) ? IMM_J : IMM_I;
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle RV32I Moore controller with registered control outputs and req/ready memory handshake.
// MC_CTRL_ILLEGAL_TRAP_EN: unsupported opcodes lock into S_TRAP with illegal_op=1 instead of executing as NOP.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.slave  bus
);
  state_t r_state, w_next;
  ctrl_t  r_ctrl;
  logic   w_fetch_done;
  always_comb begin
    w_next = S_RESET;
    case (r_state)
      S_RESET:    w_next = S_FETCH;
      S_FETCH:    w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:      w_next = S_TRAP;
`else
          default:      w_next = S_FETCH;
`endif
        endcase
      S_MEMADR:   w_next = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:     w_next = S_TRAP;
`endif
      default:    w_next = S_RESET;
    endcase
  end
  // Outputs are decoded from the next state so they are registered yet line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RESET;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_dec(w_next);
    end
  end
  assign w_fetch_done   = r_ctrl.fetch & bus.mem_ready;
  assign bus.mem_req    = r_ctrl.mem_req;
  assign bus.adr_src    = r_ctrl.adr_src;
  assign bus.mem_write  = r_ctrl.mem_write & r_ctrl.mem_req;
  assign bus.ir_write   = w_fetch_done;
  assign bus.pc_write   = w_fetch_done | r_ctrl.pc_update | (r_ctrl.branch & bus.zero);
  assign bus.reg_write  = r_ctrl.reg_write;
  assign bus.result_src = r_ctrl.result_src;
  assign bus.alu_src_a  = r_ctrl.alu_src_a;
  assign bus.alu_src_b  = r_ctrl.alu_src_b;
  assign bus.alu_op     = r_ctrl.alu_op;
  assign bus.illegal_op = r_ctrl.illegal;
  mc_imm_dec u_imm_dec (
    .i_op      (bus.op),
    .o_imm_src (bus.imm_src)
  );
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: table-driven per-cycle check of mc_ctrl_fsm outputs plus a hand-written reset-during-store sequence.
module tb_mc_ctrl_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  mc_ctrl_if bus ();
  mc_ctrl_fsm dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;
  // {illegal, mem_req adr_src mem_write ir_write pc_write reg_write, result_src, alu_src_a, alu_src_b, alu_op}
  localparam logic [14:0] E_Z    = 15'b0_000000_00_00_00_00;
  localparam logic [14:0] E_FS   = 15'b0_100000_10_00_10_00;
  localparam logic [14:0] E_FR   = 15'b0_100110_10_00_10_00;
  localparam logic [14:0] E_DEC  = 15'b0_000000_00_01_01_00;
  localparam logic [14:0] E_MA   = 15'b0_000000_00_10_01_00;
  localparam logic [14:0] E_MR   = 15'b0_110000_00_00_00_00;
  localparam logic [14:0] E_MWB  = 15'b0_000001_01_00_00_00;
  localparam logic [14:0] E_MW   = 15'b0_111000_00_00_00_00;
  localparam logic [14:0] E_XR   = 15'b0_000000_00_10_00_10;
  localparam logic [14:0] E_XI   = 15'b0_000000_00_10_01_10;
  localparam logic [14:0] E_AWB  = 15'b0_000001_00_00_00_00;
  localparam logic [14:0] E_BQ1  = 15'b0_000010_00_10_00_01;
  localparam logic [14:0] E_BQ0  = 15'b0_000000_00_10_00_01;
  localparam logic [14:0] E_JAL  = 15'b0_000010_00_01_10_00;
  localparam logic [14:0] E_TRAP = 15'b1_000000_00_00_00_00;
  typedef struct {
    string       name;
    logic        rst;
    logic [6:0]  op;
    logic        zero;
    logic        rdy;
    logic [14:0] exp;
  } vec_t;
  vec_t v[$];
  function automatic logic [1:0] imm_of(logic [6:0] o);
    return (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
  endfunction
  task automatic add(string n, logic r, logic [6:0] o, logic z, logic rd, logic [14:0] e);
    vec_t t;
    t.name = n; t.rst = r; t.op = o; t.zero = z; t.rdy = rd; t.exp = e;
    v.push_back(t);
  endtask
  task automatic check(string n, logic [14:0] e);
    logic [16:0] got, want;
    got  = {bus.illegal_op, bus.mem_req, bus.adr_src, bus.mem_write, bus.ir_write, bus.pc_write,
            bus.reg_write, bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_src};
    want = {e, imm_of(bus.op)};
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %b required %b", n, got, want);
  endtask
  initial begin
    bus.op = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) add("reset_hold", 1, 7'd0, 0, 0, E_Z);
    add("reset_release", 0, 7'd0, 0, 0, E_Z);
    add("r_fetch", 0, RT, 0, 1, E_FR);
    add("r_decode", 0, RT, 0, 1, E_DEC);
    add("r_execr", 0, RT, 0, 1, E_XR);
    add("r_aluwb", 0, RT, 0, 1, E_AWB);
    add("i_fetch_stall", 0, IT, 0, 0, E_FS);
    add("i_fetch", 0, IT, 0, 1, E_FR);
    add("i_decode", 0, IT, 0, 1, E_DEC);
    add("i_execi", 0, IT, 0, 1, E_XI);
    add("i_aluwb", 0, IT, 0, 1, E_AWB);
    add("lw_fetch", 0, LW, 0, 1, E_FR);
    add("lw_decode", 0, LW, 0, 1, E_DEC);
    add("lw_memadr", 0, LW, 0, 1, E_MA);
    add("lw_memread_w1", 0, LW, 0, 0, E_MR);
    add("lw_memread_w2", 0, LW, 0, 0, E_MR);
    add("lw_memread", 0, LW, 0, 1, E_MR);
    add("lw_memwb", 0, LW, 0, 1, E_MWB);
    add("beq1_fetch", 0, BQ, 1, 1, E_FR);
    add("beq1_decode", 0, BQ, 1, 1, E_DEC);
    add("beq1_beq", 0, BQ, 1, 1, E_BQ1);
    add("beq0_fetch", 0, BQ, 0, 1, E_FR);
    add("beq0_decode", 0, BQ, 0, 1, E_DEC);
    add("beq0_beq", 0, BQ, 0, 1, E_BQ0);
    add("jal_fetch", 0, JL, 0, 1, E_FR);
    add("jal_decode", 0, JL, 0, 1, E_DEC);
    add("jal_jal", 0, JL, 0, 1, E_JAL);
    add("jal_aluwb", 0, JL, 0, 1, E_AWB);
    add("sw_fetch", 0, SW, 0, 1, E_FR);
    add("sw_decode", 0, SW, 0, 1, E_DEC);
    add("sw_memadr", 0, SW, 0, 1, E_MA);
    add("sw_memwrite", 0, SW, 0, 1, E_MW);
    add("bad_fetch", 0, BAD, 0, 1, E_FR);
    add("bad_decode", 0, BAD, 0, 1, E_DEC);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) add("bad_trap", 0, BAD, 1, 1, E_TRAP);
`else
    add("bad_nop_fetch", 0, BAD, 0, 1, E_FR);
    add("bad_nop_decode", 0, BAD, 0, 1, E_DEC);
`endif
    foreach (v[k]) begin
      @(negedge clk);
      rst = v[k].rst; bus.op = v[k].op; bus.zero = v[k].zero; bus.mem_ready = v[k].rdy;
      #1 check(v[k].name, v[k].exp);
    end
    // Reset in the middle of a stalled store must kill mem_req/mem_write without waiting for a clock.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; bus.op = SW; bus.mem_ready = 1'b1; bus.zero = 1'b0;
    #1 check("sw2_reset_state", E_Z);
    @(negedge clk); #1 check("sw2_fetch", E_FR);
    @(negedge clk); #1 check("sw2_decode", E_DEC);
    @(negedge clk); #1 check("sw2_memadr", E_MA);
    @(negedge clk); bus.mem_ready = 1'b0;
    #1 check("sw2_memwrite_stall", E_MW);
    #2 rst = 1'b1;
    #1 check("sw2_abort_async", E_Z);
    @(negedge clk); rst = 1'b0;
    #1 check("sw2_after_abort", E_Z);
    @(negedge clk); #1 check("sw2_restart_fetch", E_FS);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
